// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// One restoring radix-2 step per clock. Divide-by-zero and signed
// overflow are resolved on the accepting edge and skip the iteration.
module div_unit #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   OP,
    output logic [N-1:0] RESULT,
    output logic         BUSY,
    output logic         DONE
);

    localparam int                CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]      ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]      MIN_NEG  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Two's-complement negation
    function automatic logic [N-1:0] neg_f(input logic [N-1:0] x);
        neg_f = ~x + ONE_N;
    endfunction

    // Magnitude of a signed value (MIN_NEG maps to itself, read as unsigned)
    function automatic logic [N-1:0] abs_f(input logic [N-1:0] x);
        abs_f = x[N-1] ? neg_f(x) : x;
    endfunction

    state_t            state_r, state_nx;
    logic [N-1:0]      rem_r, rem_nx;
    logic [N-1:0]      quo_r, quo_nx;
    logic [N-1:0]      div_r, div_nx;
    logic [CNT_W-1:0]  cnt_r, cnt_nx;
    logic              qsign_r, qsign_nx;
    logic              rsign_r, rsign_nx;
    logic              selrem_r, selrem_nx;
    logic [N-1:0]      result_r, result_nx;
    logic              busy_r;
    logic              done_r;

    logic              is_signed_s;
    logic              ovf_s;
    logic [N:0]        rem_sh_s;
    logic [N-1:0]      trial_s;
    logic              ge_s;
    logic [N-1:0]      rem_step_s;
    logic [N-1:0]      quo_step_s;
    logic [N-1:0]      q_fin_s;
    logic [N-1:0]      r_fin_s;

    assign is_signed_s = ~OP[0];
    assign ovf_s       = is_signed_s && (A == MIN_NEG) && (B == {N{1'b1}});

    // Single restoring step: shift remainder:quotient, trial-subtract divisor
    always_comb begin
        rem_sh_s = {rem_r, quo_r[N-1]};
        trial_s  = rem_sh_s[N-1:0] - div_r;
        ge_s     = (rem_sh_s >= {1'b0, div_r});
        if (ge_s) begin
            rem_step_s = trial_s;
            quo_step_s = {quo_r[N-2:0], 1'b1};
        end else begin
            rem_step_s = rem_sh_s[N-1:0];
            quo_step_s = {quo_r[N-2:0], 1'b0};
        end
        q_fin_s = qsign_r ? neg_f(quo_step_s) : quo_step_s;
        r_fin_s = rsign_r ? neg_f(rem_step_s) : rem_step_s;
    end

    // Next-state and datapath update decisions
    always_comb begin
        state_nx  = state_r;
        rem_nx    = rem_r;
        quo_nx    = quo_r;
        div_nx    = div_r;
        cnt_nx    = cnt_r;
        qsign_nx  = qsign_r;
        rsign_nx  = rsign_r;
        selrem_nx = selrem_r;
        result_nx = result_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    if (B == {N{1'b0}}) begin
                        state_nx  = ST_DONE;
                        result_nx = OP[1] ? A : {N{1'b1}};
                    end else if (ovf_s) begin
                        state_nx  = ST_DONE;
                        result_nx = OP[1] ? {N{1'b0}} : A;
                    end else begin
                        state_nx  = ST_CALC;
                        rem_nx    = {N{1'b0}};
                        quo_nx    = is_signed_s ? abs_f(A) : A;
                        div_nx    = is_signed_s ? abs_f(B) : B;
                        qsign_nx  = is_signed_s & (A[N-1] ^ B[N-1]);
                        rsign_nx  = is_signed_s & A[N-1];
                        selrem_nx = OP[1];
                        cnt_nx    = CNT_MAX;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CALC: begin
                rem_nx = rem_step_s;
                quo_nx = quo_step_s;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx  = ST_DONE;
                    result_nx = selrem_r ? r_fin_s : q_fin_s;
                end else begin
                    cnt_nx = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r  <= ST_IDLE;
            rem_r    <= {N{1'b0}};
            quo_r    <= {N{1'b0}};
            div_r    <= {N{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            qsign_r  <= 1'b0;
            rsign_r  <= 1'b0;
            selrem_r <= 1'b0;
            result_r <= {N{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx;
            rem_r    <= rem_nx;
            quo_r    <= quo_nx;
            div_r    <= div_nx;
            cnt_r    <= cnt_nx;
            qsign_r  <= qsign_nx;
            rsign_r  <= rsign_nx;
            selrem_r <= selrem_nx;
            result_r <= result_nx;
            busy_r   <= (state_nx == ST_CALC);
            done_r   <= (state_nx == ST_DONE);
        end
    end

    assign RESULT = result_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit for the execute stage, alongside the combinational add/sub/SLT unit.
- Takes the same rs1/rs2 operands the add/sub/SLT unit receives.
- Produces DIV/DIVU/REM/REMU results over multiple cycles through a START/BUSY/DONE handshake.
- Control logic stalls the pipeline while BUSY is high.

Parameters:
N, 32, operand and result width in bits (N >= 4).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RSTN  input  1  asynchronous active-low reset.
START  input  1  request a new operation; sampled on the rising edge.
A  input  N  dividend (rs1); sampled only on the accepting edge.
B  input  N  divisor (rs2); sampled only on the accepting edge.
OP  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled only on the accepting edge.
RESULT  output  N  quotient or remainder; registered.
BUSY  output  1  high while iterating; START is ignored while BUSY is high.
DONE  output  1  one-cycle pulse marking RESULT valid.

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE, RESULT = 0, BUSY = 0, DONE = 0, internal registers cleared.
  - Reset mid-operation aborts immediately; no DONE is produced.
- States: IDLE, CALC, DONE.
- Accepting edge: rising edge with START = 1 while state is IDLE or DONE.
  - Back-to-back operations are allowed: START during the DONE cycle is accepted.
- Normal path:
  - Accepting edge latches absolute values |A| and |B| for signed ops (OP[0] = 0), raw values for unsigned ops.
  - Same edge latches quotient sign = A[N-1] ^ B[N-1] and remainder sign = A[N-1] (signed ops only), then enters CALC with iteration counter = N-1.
- CALC:
  - One restoring radix-2 step per edge: shift remainder:quotient left 1; trial-subtract divisor; if no borrow, keep difference and set quotient LSB to 1.
  - BUSY = 1 throughout CALC.
  - On the edge where the counter reads 0 (the Nth step), apply sign correction.
  - Quotient is negated if quotient sign = 1; remainder is negated if remainder sign = 1.
  - Load RESULT with quotient when OP[1] = 0, remainder when OP[1] = 1, and enter DONE.
- Normal-path latency: DONE is high in the cycle starting N edges after the accepting edge.
  - BUSY is high for exactly N cycles.
- DONE state lasts one cycle: DONE = 1, BUSY = 0.
  - Next edge goes to CALC if START = 1, otherwise IDLE.
- RESULT holds its value through IDLE until the next completion or reset.
- Fast path: decided on the accepting edge; skips CALC, enters DONE directly with RESULT loaded; DONE is high one cycle after acceptance.
  - Divide by zero (B = 0): quotient = all ones; remainder = A. Applies to both signed and unsigned ops.
  - Signed overflow (DIV/REM, A = 1 followed by N-1 zeros, B = all ones): quotient = A, remainder = 0.
- START while in CALC is ignored; A/B/OP changes during CALC have no effect.
- DONE and BUSY are never high simultaneously.

Test Plan:
- Reset, then DIVU A=100, B=7: BUSY high exactly 32 cycles, DONE pulse on the 32nd cycle after accept, RESULT = 14. Repeat with REMU: RESULT = 2.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). REM A=7, B=0xFFFFFFFE (-2) -> 1.
- DIVU A=5, B=0 -> 0xFFFFFFFF, DONE one cycle after accept, BUSY never high. REM A=0xFFFFFFF9, B=0 -> 0xFFFFFFF9.
- DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000 via fast path. REM same operands -> 0.
- START pulsed with DIVU 9/3 mid-CALC of DIVU 100/7: result still 14, latency unchanged. START asserted in the DONE cycle with DIVU 9/3: second DONE exactly 32 cycles later, RESULT = 3.
- RSTN low for 1 cycle, 10 cycles into CALC: BUSY, DONE and RESULT go to 0 immediately and no DONE follows. A fresh DIVU 50/5 then gives 10.
